// File: rtl/video_pkg.sv
// Shared definitions for the pixel filter pipeline: default widths,
// luma weights and the effect-mode encoding.
package video_pkg;

  localparam int DEF_R_W   = 5;
  localparam int DEF_G_W   = 6;
  localparam int DEF_B_W   = 5;
  localparam int DEF_OUT_W = 10;
  localparam int DEF_ACC_W = 29;
  localparam int DEF_CNT_W = 20;

  // BT.601-style weights scaled so they sum to 256
  localparam int LUMA_CR    = 77;
  localparam int LUMA_CG    = 150;
  localparam int LUMA_CB    = 29;
  localparam int LUMA_SHIFT = 8;

  typedef enum logic [2:0] {
    MODE_PASS       = 3'd0,
    MODE_GREY       = 3'd1,
    MODE_INVERT     = 3'd2,
    MODE_THRESH     = 3'd3,
    MODE_R_ONLY     = 3'd4,
    MODE_G_ONLY     = 3'd5,
    MODE_B_ONLY     = 3'd6,
    MODE_INV_THRESH = 3'd7
  } mode_e;

endpackage

// File: rtl/px_expand.sv
// Widens one colour channel by cyclic bit replication so that full-scale
// input maps to full-scale output.
module px_expand #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 10
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_rep
    assign out_o[gi] = in_i[IN_W-1-((OUT_W-1-gi) % IN_W)];
  end

endmodule

// File: rtl/video_filter_pipe.sv
// Three-stage pixel filter: expand -> luma -> mode mux, with frame-synchronous
// mode/threshold latching and per-frame luminance statistics.
module video_filter_pipe
  import video_pkg::*;
#(
  parameter int R_W   = DEF_R_W,
  parameter int G_W   = DEF_G_W,
  parameter int B_W   = DEF_B_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   CLOCK_25,
  input  logic                   RST_N,
  input  logic [R_W+G_W+B_W-1:0] PIX_IN,
  input  logic                   IN_VALID,
  input  logic                   IN_HS,
  input  logic                   IN_VS,
  input  logic [2:0]             SEL,
  input  logic [OUT_W-1:0]       THRESH,
  output logic [OUT_W-1:0]       R,
  output logic [OUT_W-1:0]       G,
  output logic [OUT_W-1:0]       B,
  output logic                   OUT_VALID,
  output logic                   OUT_HS,
  output logic                   OUT_VS,
  output logic [ACC_W-1:0]       LUMA_SUM,
  output logic [CNT_W-1:0]       PIX_COUNT,
  output logic                   STAT_VALID
);

  localparam int PIX_W = R_W + G_W + B_W;
  localparam int LW    = OUT_W + LUMA_SHIFT;

  logic [OUT_W-1:0] r_exp, g_exp, b_exp;

  logic [OUT_W-1:0] r1_q, g1_q, b1_q;
  logic             v1_q, hs1_q, vs1_q;
  logic [OUT_W-1:0] r2_q, g2_q, b2_q, y2_q;
  logic             v2_q, hs2_q, vs2_q;
  logic [OUT_W-1:0] r3_q, g3_q, b3_q;
  logic             v3_q, hs3_q, vs3_q;

  logic [OUT_W-1:0] r3_d, g3_d, b3_d, y2_d;
  logic [LW-1:0]    luma_full;

  logic             vs_in_q;
  logic             vs_in_fall;
  mode_e            mode_q;
  logic [OUT_W-1:0] thr_q;
  logic             thr_hit;

  logic [ACC_W-1:0] acc_q, acc_sat;
  logic [CNT_W-1:0] cnt_q, cnt_sat;
  logic [ACC_W:0]   acc_ext;
  logic [CNT_W:0]   cnt_ext;
  logic [OUT_W-1:0] y_add;
  logic [ACC_W-1:0] luma_sum_q;
  logic [CNT_W-1:0] pix_count_q;
  logic             stat_valid_q;
  logic             vs2_fall;

  px_expand #(.IN_W(R_W), .OUT_W(OUT_W)) u_exp_r (
    .in_i  (PIX_IN[PIX_W-1 -: R_W]),
    .out_o (r_exp)
  );

  px_expand #(.IN_W(G_W), .OUT_W(OUT_W)) u_exp_g (
    .in_i  (PIX_IN[G_W+B_W-1 -: G_W]),
    .out_o (g_exp)
  );

  px_expand #(.IN_W(B_W), .OUT_W(OUT_W)) u_exp_b (
    .in_i  (PIX_IN[B_W-1:0]),
    .out_o (b_exp)
  );

  always_comb begin
    luma_full = LW'(LUMA_CR) * LW'(r1_q)
              + LW'(LUMA_CG) * LW'(g1_q)
              + LW'(LUMA_CB) * LW'(b1_q);
    y2_d      = luma_full[LUMA_SHIFT +: OUT_W];
  end

  always_comb begin
    r3_d    = r2_q;
    g3_d    = g2_q;
    b3_d    = b2_q;
    thr_hit = (y2_q >= thr_q);
    case (mode_q)
      MODE_PASS: ;
      MODE_GREY: begin
        r3_d = y2_q;
        g3_d = y2_q;
        b3_d = y2_q;
      end
      MODE_INVERT: begin
        r3_d = ~r2_q;
        g3_d = ~g2_q;
        b3_d = ~b2_q;
      end
      MODE_THRESH: begin
        r3_d = {OUT_W{thr_hit}};
        g3_d = {OUT_W{thr_hit}};
        b3_d = {OUT_W{thr_hit}};
      end
      MODE_R_ONLY: begin
        g3_d = '0;
        b3_d = '0;
      end
      MODE_G_ONLY: begin
        r3_d = '0;
        b3_d = '0;
      end
      MODE_B_ONLY: begin
        r3_d = '0;
        g3_d = '0;
      end
      MODE_INV_THRESH: begin
        r3_d = {OUT_W{~thr_hit}};
        g3_d = {OUT_W{~thr_hit}};
        b3_d = {OUT_W{~thr_hit}};
      end
      default: ;
    endcase
    // Blanking must reach the DAC as black regardless of effect
    if (!v2_q) begin
      r3_d = '0;
      g3_d = '0;
      b3_d = '0;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge RST_N) begin
    if (!RST_N) begin
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
      v1_q  <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      r2_q  <= '0;
      g2_q  <= '0;
      b2_q  <= '0;
      y2_q  <= '0;
      v2_q  <= 1'b0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      r3_q  <= '0;
      g3_q  <= '0;
      b3_q  <= '0;
      v3_q  <= 1'b0;
      hs3_q <= 1'b1;
      vs3_q <= 1'b1;
    end else begin
      r1_q  <= r_exp;
      g1_q  <= g_exp;
      b1_q  <= b_exp;
      v1_q  <= IN_VALID;
      hs1_q <= IN_HS;
      vs1_q <= IN_VS;
      r2_q  <= r1_q;
      g2_q  <= g1_q;
      b2_q  <= b1_q;
      y2_q  <= y2_d;
      v2_q  <= v1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      r3_q  <= r3_d;
      g3_q  <= g3_d;
      b3_q  <= b3_d;
      v3_q  <= v2_q;
      hs3_q <= hs2_q;
      vs3_q <= vs2_q;
    end
  end

  // Syncs idle high, so the edge detector also resets high to avoid a false edge
  assign vs_in_fall = vs_in_q & ~IN_VS;

  always_ff @(posedge CLOCK_25 or negedge RST_N) begin
    if (!RST_N) begin
      vs_in_q <= 1'b1;
      mode_q  <= MODE_PASS;
      thr_q   <= '0;
    end else begin
      vs_in_q <= IN_VS;
      if (vs_in_fall) begin
        mode_q <= mode_e'(SEL);
        thr_q  <= THRESH;
      end
    end
  end

  // vs3_q is vs2_q one cycle later, which gives the stage-2 edge directly
  assign vs2_fall = vs3_q & ~vs2_q;

  always_comb begin
    y_add   = v2_q ? y2_q : '0;
    acc_ext = {1'b0, acc_q} + (ACC_W+1)'(y_add);
    cnt_ext = {1'b0, cnt_q} + (CNT_W+1)'(v2_q);
    acc_sat = acc_ext[ACC_W] ? '1 : acc_ext[ACC_W-1:0];
    cnt_sat = cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];
  end

  always_ff @(posedge CLOCK_25 or negedge RST_N) begin
    if (!RST_N) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      luma_sum_q   <= '0;
      pix_count_q  <= '0;
      stat_valid_q <= 1'b0;
    end else if (vs2_fall) begin
      luma_sum_q   <= acc_sat;
      pix_count_q  <= cnt_sat;
      acc_q        <= '0;
      cnt_q        <= '0;
      stat_valid_q <= 1'b1;
    end else begin
      acc_q        <= acc_sat;
      cnt_q        <= cnt_sat;
      stat_valid_q <= 1'b0;
    end
  end

  assign R          = r3_q;
  assign G          = g3_q;
  assign B          = b3_q;
  assign OUT_VALID  = v3_q;
  assign OUT_HS     = hs3_q;
  assign OUT_VS     = vs3_q;
  assign LUMA_SUM   = luma_sum_q;
  assign PIX_COUNT  = pix_count_q;
  assign STAT_VALID = stat_valid_q;

endmodule

// File: tb/tb_video_filter_pipe.sv
// Directed bench for video_filter_pipe: latency, all eight modes, frame-sync
// latching, frame statistics and mid-line reset.
module tb_video_filter_pipe;

  logic        CLOCK_25;
  logic        RST_N;
  logic [15:0] PIX_IN;
  logic        IN_VALID;
  logic        IN_HS;
  logic        IN_VS;
  logic [2:0]  SEL;
  logic [9:0]  THRESH;
  logic [9:0]  R;
  logic [9:0]  G;
  logic [9:0]  B;
  logic        OUT_VALID;
  logic        OUT_HS;
  logic        OUT_VS;
  logic [28:0] LUMA_SUM;
  logic [19:0] PIX_COUNT;
  logic        STAT_VALID;

  int n_checks = 0;
  int n_fail   = 0;

  video_filter_pipe dut (
    .CLOCK_25   (CLOCK_25),
    .RST_N      (RST_N),
    .PIX_IN     (PIX_IN),
    .IN_VALID   (IN_VALID),
    .IN_HS      (IN_HS),
    .IN_VS      (IN_VS),
    .SEL        (SEL),
    .THRESH     (THRESH),
    .R          (R),
    .G          (G),
    .B          (B),
    .OUT_VALID  (OUT_VALID),
    .OUT_HS     (OUT_HS),
    .OUT_VS     (OUT_VS),
    .LUMA_SUM   (LUMA_SUM),
    .PIX_COUNT  (PIX_COUNT),
    .STAT_VALID (STAT_VALID)
  );

  initial CLOCK_25 = 1'b0;
  always #20 CLOCK_25 = ~CLOCK_25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic idle();
    PIX_IN   = 16'h0000;
    IN_VALID = 1'b0;
    IN_HS    = 1'b1;
    IN_VS    = 1'b1;
  endtask

  // One isolated input cycle; outputs checked exactly three edges later
  task automatic probe(input string tag, input logic [15:0] pix, input logic v,
                       input logic hs, input logic vs,
                       input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
    PIX_IN   = pix;
    IN_VALID = v;
    IN_HS    = hs;
    IN_VS    = vs;
    tick();
    idle();
    tick();
    check({tag, ".early_valid"}, 32'(OUT_VALID), 32'd0);
    tick();
    check({tag, ".r"},  32'(R),         32'(er));
    check({tag, ".g"},  32'(G),         32'(eg));
    check({tag, ".b"},  32'(B),         32'(eb));
    check({tag, ".v"},  32'(OUT_VALID), 32'(v));
    check({tag, ".hs"}, 32'(OUT_HS),    32'(hs));
    check({tag, ".vs"}, 32'(OUT_VS),    32'(vs));
  endtask

  task automatic vs_pulse(input string tag, input logic [2:0] sel, input logic [9:0] thr);
    SEL    = sel;
    THRESH = thr;
    probe(tag, 16'h0000, 1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N  = 1'b0;
    SEL    = 3'd0;
    THRESH = 10'h000;
    idle();
    tick();
    tick();
    check("rst.r",     32'(R),          32'd0);
    check("rst.valid", 32'(OUT_VALID),  32'd0);
    check("rst.hs",    32'(OUT_HS),     32'd1);
    check("rst.vs",    32'(OUT_VS),     32'd1);
    check("rst.luma",  32'(LUMA_SUM),   32'd0);
    check("rst.count", 32'(PIX_COUNT),  32'd0);
    check("rst.stat",  32'(STAT_VALID), 32'd0);
    RST_N = 1'b1;
    tick();

    // Pass-through and latency, including a VS pulse through the sync path
    vs_pulse("pass.vs", 3'd0, 10'h000);
    probe("pass.ffff", 16'hFFFF, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    tick();
    check("pass.blank_r", 32'(R),         32'd0);
    check("pass.blank_v", 32'(OUT_VALID), 32'd0);
    probe("pass.8410", 16'h8410, 1'b1, 1'b1, 1'b1, 10'h210, 10'h208, 10'h210);

    vs_pulse("grey.vs", 3'd1, 10'h000);
    probe("grey.f800", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h133, 10'h133, 10'h133);

    vs_pulse("inv.vs", 3'd2, 10'h000);
    probe("inv.0000", 16'h0000, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);

    vs_pulse("thr.vs", 3'd3, 10'h200);
    probe("thr.ffff", 16'hFFFF, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    probe("thr.f800", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000);
    THRESH = 10'h000;
    probe("thr.hold", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000);

    vs_pulse("ithr.vs", 3'd7, 10'h200);
    probe("ithr.ffff", 16'hFFFF, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000);
    probe("ithr.f800", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);

    vs_pulse("ronly.vs", 3'd4, 10'h000);
    probe("ronly.8410", 16'h8410, 1'b1, 1'b1, 1'b1, 10'h210, 10'h000, 10'h000);
    vs_pulse("gonly.vs", 3'd5, 10'h000);
    probe("gonly.8410", 16'h8410, 1'b1, 1'b1, 1'b1, 10'h000, 10'h208, 10'h000);
    vs_pulse("bonly.vs", 3'd6, 10'h000);
    probe("bonly.8410", 16'h8410, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 10'h210);

    // SEL change without a VS edge must not take effect
    vs_pulse("latch.vs0", 3'd0, 10'h000);
    SEL = 3'd1;
    probe("latch.mid", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h000, 10'h000);
    vs_pulse("latch.vs1", 3'd1, 10'h000);
    probe("latch.new", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h133, 10'h133, 10'h133);

    // Frame A: four full-white pixels
    vs_pulse("statA.open", 3'd0, 10'h000);
    for (int i = 0; i < 4; i++)
      probe("statA.px", 16'hFFFF, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    vs_pulse("statA.close", 3'd0, 10'h000);
    check("statA.stat",  32'(STAT_VALID), 32'd1);
    check("statA.luma",  32'(LUMA_SUM),   32'd4092);
    check("statA.count", 32'(PIX_COUNT),  32'd4);
    tick();
    check("statA.pulse_end", 32'(STAT_VALID), 32'd0);

    // Frame B: empty
    vs_pulse("statB.close", 3'd0, 10'h000);
    check("statB.stat",  32'(STAT_VALID), 32'd1);
    check("statB.luma",  32'(LUMA_SUM),   32'd0);
    check("statB.count", 32'(PIX_COUNT),  32'd0);

    // VS edges two cycles apart each report
    IN_VS = 1'b0;
    tick();
    IN_VS = 1'b1;
    tick();
    IN_VS = 1'b0;
    tick();
    check("b2b.stat1", 32'(STAT_VALID), 32'd1);
    IN_VS = 1'b1;
    tick();
    check("b2b.gap", 32'(STAT_VALID), 32'd0);
    tick();
    check("b2b.stat2", 32'(STAT_VALID), 32'd1);
    tick();
    check("b2b.end", 32'(STAT_VALID), 32'd0);

    // Frame C: closing edge itself carries a valid pixel that must be counted
    probe("statC.px", 16'hFFFF, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    probe("statC.px", 16'hFFFF, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    probe("statC.edge", 16'hFFFF, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF);
    check("statC.stat",  32'(STAT_VALID), 32'd1);
    check("statC.luma",  32'(LUMA_SUM),   32'd3069);
    check("statC.count", 32'(PIX_COUNT),  32'd3);

    // Reset while a grey-mode line is streaming
    vs_pulse("rstm.vs", 3'd1, 10'h000);
    PIX_IN   = 16'hFFFF;
    IN_VALID = 1'b1;
    IN_HS    = 1'b0;
    tick();
    tick();
    tick();
    check("rstm.pre_r",  32'(R),         32'h3FF);
    check("rstm.pre_hs", 32'(OUT_HS),    32'd0);
    RST_N = 1'b0;
    #1;
    check("rstm.r",     32'(R),          32'd0);
    check("rstm.g",     32'(G),          32'd0);
    check("rstm.b",     32'(B),          32'd0);
    check("rstm.valid", 32'(OUT_VALID),  32'd0);
    check("rstm.hs",    32'(OUT_HS),     32'd1);
    check("rstm.vs",    32'(OUT_VS),     32'd1);
    check("rstm.luma",  32'(LUMA_SUM),   32'd0);
    check("rstm.count", 32'(PIX_COUNT),  32'd0);
    tick();
    idle();
    tick();
    RST_N = 1'b1;
    probe("rstm.after", 16'hF800, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h000, 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_filter_pipe.md
Name: video_filter_pipe

Overview:
Parameterised, pipelined successor to the combinational VGA colour filter. It sits between the SDRAM frame reader's packed-pixel output and the VGA DAC pins, in the CLOCK_25 pixel domain. It expands packed RGB to DAC width and applies one of eight selectable effects. Mode changes take effect only on frame boundaries, and the block reports per-frame luminance statistics.

Parameters:
R_W, 5, red field width of packed input
G_W, 6, green field width
B_W, 5, blue field width
OUT_W, 10, DAC channel width
ACC_W, 29, luma accumulator width
CNT_W, 20, valid-pixel counter width

Ports:
CLOCK_25  in  1  pixel clock
RST_N  in  1  asynchronous active-low reset
PIX_IN  in  R_W+G_W+B_W  packed pixel {R,G,B}, MSB = red
IN_VALID  in  1  pixel active (not blanking)
IN_HS  in  1  hsync, active low
IN_VS  in  1  vsync, active low
SEL  in  3  requested mode
THRESH  in  OUT_W  threshold for modes 3/7
R, G, B  out  OUT_W each  DAC data
OUT_VALID  out  1  delayed IN_VALID
OUT_HS, OUT_VS  out  1 each  delayed syncs
LUMA_SUM  out  ACC_W  luma sum of the last completed frame
PIX_COUNT  out  CNT_W  valid-pixel count of the last completed frame
STAT_VALID  out  1  one-cycle pulse when LUMA_SUM/PIX_COUNT update

Behaviour:
- Reset (RST_N low, async): all pipeline registers 0; R/G/B/OUT_VALID 0; OUT_HS/OUT_VS 1; active mode 0; latched threshold 0; accumulator, counter, LUMA_SUM, PIX_COUNT 0; STAT_VALID 0. Reset mid-line drops all in-flight pixels.
- Latency: fixed 3 cycles for data, valid and syncs. Syncs are delayed through the same registers as the data.
- Stage 1, expand: each channel is widened to OUT_W by cyclic bit replication, i.e. out[i] = in[W-1-((OUT_W-1-i) mod W)]. 5'h1F gives 10'h3FF; 5'h10 gives 10'h210; 6'h3F gives 10'h3FF.
- Stage 2, luma: Y = (77*R + 150*G + 29*B) >> 8, computed on expanded channels with an OUT_W+8 bit intermediate and truncated to OUT_W. Expanded R/G/B are carried alongside.
- Stage 3, mode mux, registered:
  - 0: pass
  - 1: grey (Y,Y,Y)
  - 2: invert (~R,~G,~B)
  - 3: threshold, all 3FF if Y >= thr, else 0
  - 4: R only
  - 5: G only
  - 6: B only
  - 7: inverted threshold
- R/G/B are forced to 0 whenever stage-3 valid is low.
- Mode/threshold latch: on the cycle IN_VS goes 1->0 (registered edge detect), SEL is latched into active mode and THRESH into thr. Otherwise both hold. SEL changes mid-frame have no visible effect. Both are applied at stage 3.
- Statistics: run on stage-2-aligned valid, Y and VS.
  - Each valid cycle: acc += Y and cnt += 1. Both saturate at all-ones and never wrap.
  - On a stage-2 VS falling edge: LUMA_SUM <= acc + (Y if valid), PIX_COUNT <= cnt + valid (same saturation). acc and cnt then clear to 0, and STAT_VALID pulses for 1 cycle.
  - The first edge after reset reports the partial frame; that is accepted.
- Back-to-back VS edges two cycles apart: each produces its own pulse.

Decomposition:
- Shared package video_pkg: mode encodings (MODE_PASS..MODE_INV_THRESH), luma coefficients 77/150/29 with shift 8, and default widths.
- One sub-module, px_expand (combinational cyclic replication, parameterised IN_W/OUT_W), instantiated three times.

Test Plan:
- Pass-through: SEL=0, VS pulse, PIX_IN=16'hFFFF with IN_VALID=1 -> R=G=B=10'h3FF exactly 3 cycles later; HS/VS delayed by 3.
- Grey: SEL=1 latched, PIX_IN=16'hF800 -> R=G=B=10'h133 (Y=307). Invert: SEL=2, PIX_IN=16'h0000 -> all 10'h3FF.
- Threshold: SEL=3, THRESH=10'h200; 16'hFFFF -> 3FF,3FF,3FF; 16'hF800 -> 0,0,0. With SEL=7 both results swap.
- Frame-sync latch: in mode 0, change SEL to 1 while IN_VS=1 -> output stays pass-through; after IN_VS falls, the next valid 16'hF800 gives 10'h133.
- Stats: a frame of 4 valid 16'hFFFF pixels between VS edges -> STAT_VALID one pulse, LUMA_SUM=4092, PIX_COUNT=4. A following frame with no valid pixels -> 0/0.
- Reset mid-line: drop RST_N while valid data streams -> R/G/B/OUT_VALID 0 immediately, OUT_HS/OUT_VS 1, mode back to 0; after release, first output 3 cycles after the first new input.
